mem_arbiter: RTL and testbench

Single-port main-memory arbiter and sequencer shared by the instruction-cache fill path and the data-cache fill/write path. It accepts a block-fill or single-word write transaction from one requester at a time. It drives the multi-cycle pipelined main memory, streams returned words back to the granted cache, and signals completion. It replaces ad-hoc cross-gating between the two cache fill FSMs with one owner of the memory port.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam int unsigned DEF_WORDS   = 8;
  localparam int unsigned DEF_MEM_LAT = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner select between the I and D requesters.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise D has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_d_i,
  output logic win_i_o,
  output logic win_d_o
);

  logic prefer_d;

`ifdef MEM_ARB_RR_EN
  assign prefer_d = !last_d_i;
`else
  logic unused_last;
  assign unused_last = last_d_i;
  assign prefer_d    = 1'b1;
`endif

  always_comb begin
    win_i_o = 1'b0;
    win_d_o = 1'b0;
    if (i_req_i && d_req_i) begin
      win_d_o = prefer_d;
      win_i_o = !prefer_d;
    end else begin
      win_i_o = i_req_i;
      win_d_o = d_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter/sequencer for I-cache fills and D-cache fills/writes.
// Collision policy is set by the MEM_ARB_RR_EN macro (see arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned WORDS   = DEF_WORDS,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     i_gnt,
  output logic                     d_gnt,
  output logic                     i_done,
  output logic                     d_done,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     fill_valid,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_valid
);

  localparam int unsigned CNT_W = $clog2(WORDS);
  localparam int unsigned OFF_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:1]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    issue_q, issue_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic                last_d_q, last_d_d;
  logic                win_i, win_d;
  logic                ret_ok;

  // Byte-address bit 0 never reaches memory: accesses are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[0], d_addr[0]};

  arb_pick u_pick (
    .i_req_i  (i_req),
    .d_req_i  (d_req),
    .last_d_i (last_d_q),
    .win_i_o  (win_i),
    .win_d_o  (win_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      issue_q  <= '0;
      ret_q    <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      issue_q  <= issue_d;
      ret_q    <= ret_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    issue_d    = issue_q;
    ret_d      = ret_q;
    last_d_d   = last_d_q;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    fill_valid = 1'b0;
    fill_data  = '0;
    fill_word  = '0;

    unique case (state_q)
      IDLE: begin
        if (win_i || win_d) begin
          owner_d  = win_d ? OWN_D : OWN_I;
          last_d_d = win_d;
          addr_d   = win_d ? d_addr[ADDR_W-1:1] : i_addr[ADDR_W-1:1];
          wdata_d  = d_wdata;
          issue_d  = '0;
          ret_d    = '0;
          state_d  = (win_d && d_wr) ? WRITE : ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:OFF_W], issue_q, 1'b0};
        issue_d  = issue_q + 1'b1;
        if (issue_q == LAST) state_d = WAIT;
      end
      WAIT: ;
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q;
        d_done    = 1'b1;
        owner_d   = OWN_NONE;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Returns are evaluated after the case so the final return overrides ISSUE->WAIT.
    ret_ok = mem_valid && (state_q == ISSUE || state_q == WAIT);
    if (ret_ok) begin
      fill_valid = 1'b1;
      fill_data  = mem_data;
      fill_word  = ret_q;
      ret_d      = ret_q + 1'b1;
      if (ret_q == LAST) begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    end
  end

  assign i_gnt = (owner_q == OWN_I);
  assign d_gnt = (owner_q == OWN_D);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a pipelined memory model and a transaction-level reference.
module tb_mem_arbiter;

  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;
  localparam int FILL_CYC = WORDS + MEM_LAT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        i_gnt, d_gnt, i_done, d_done;
  logic [15:0] fill_data;
  logic        fill_valid;
  logic [2:0]  fill_word;
  logic        busy;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        stray_v = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_d_m = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_done(i_done), .d_done(d_done),
    .fill_data(fill_data), .fill_valid(fill_valid), .fill_word(fill_word),
    .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_data(mem_data), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  // Memory: a read accepted at an edge returns MEM_LAT cycles after the cycle it was issued in.
  logic [15:0] pipe_a [MEM_LAT];
  logic        pipe_v [MEM_LAT];
  always @(posedge clk) begin
    pipe_v[0] <= mem_en && !mem_wr;
    pipe_a[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_a[k] <= pipe_a[k-1];
    end
  end
  assign mem_valid = pipe_v[MEM_LAT-1] | stray_v;
  assign mem_data  = memfn(pipe_a[MEM_LAT-1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_d(input bit ir, input bit dr, input bit last_d);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // Entered at the negedge of grant cycle T; returns at the negedge of the done cycle.
  task automatic expect_fill(input bit is_d, input logic [15:0] addr, input int drop_at, input int abort_at);
    logic [15:0] base;
    bit fv, last;
    base = {addr[15:4], 4'h0};
    for (int k = 0; k < FILL_CYC; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) begin
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
      end
      #1;
      chk("i_gnt", i_gnt, !is_d);
      chk("d_gnt", d_gnt, is_d);
      chk("busy", busy, 1);
      chk("mem_en", mem_en, k < WORDS);
      if (k < WORDS) begin
        chk("mem_wr", mem_wr, 0);
        chk("mem_addr", mem_addr, base + 16'(2 * k));
      end
      fv = (k >= MEM_LAT);
      chk("fill_valid", fill_valid, fv);
      if (fv) begin
        chk("fill_word", fill_word, k - MEM_LAT);
        chk("fill_data", fill_data, memfn(base + 16'(2 * (k - MEM_LAT))));
      end
      last = (k == FILL_CYC - 1);
      chk("i_done", i_done, last && !is_d);
      chk("d_done", d_done, last && is_d);
      if (k == abort_at) return;
    end
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
  endtask

  task automatic expect_write(input logic [15:0] addr, input logic [15:0] wdata);
    #1;
    chk("w_d_gnt", d_gnt, 1);
    chk("w_i_gnt", i_gnt, 0);
    chk("w_mem_en", mem_en, 1);
    chk("w_mem_wr", mem_wr, 1);
    chk("w_mem_addr", mem_addr, {addr[15:1], 1'b0});
    chk("w_mem_wdata", mem_wdata, wdata);
    chk("w_d_done", d_done, 1);
    chk("w_i_done", i_done, 0);
    d_req = 1'b0;
  endtask

  task automatic idle_gap();
    @(negedge clk);
    #1;
    chk("gap_i_gnt", i_gnt, 0);
    chk("gap_d_gnt", d_gnt, 0);
    chk("gap_busy", busy, 0);
    chk("gap_mem_en", mem_en, 0);
    chk("gap_fill_valid", fill_valid, 0);
    chk("gap_done", {i_done, d_done}, 0);
  endtask

  // Called at the negedge before the sampling edge; serves whichever requester the model picks.
  task automatic serve();
    bit win_d;
    logic [15:0] a, w;
    bit wr;
    win_d = pick_d(i_req, d_req, last_d_m);
    last_d_m = win_d;
    a  = win_d ? d_addr : i_addr;
    w  = d_wdata;
    wr = win_d && d_wr;
    @(negedge clk);
    if (wr) expect_write(a, w);
    else    expect_fill(win_d, a, -1, -1);
  endtask

  task automatic raise_random();
    int unsigned r;
    r = $urandom_range(0, 2);
    if (r != 1) begin
      i_req = 1'b1; i_addr = 16'($urandom);
    end
    if (r != 0) begin
      d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
      d_addr = 16'($urandom); d_wdata = 16'($urandom);
    end
  endtask

  task automatic stray_pulse();
    stray_v = 1'b1;
    #1;
    chk("stray_fill_valid", fill_valid, 0);
    chk("stray_busy", busy, 0);
    @(negedge clk);
    stray_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", {mem_en, mem_wr}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_done", {i_done, d_done}, 0);
    rst = 1'b0;
    @(negedge clk);

    stray_pulse();

    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0402; d_wdata = 16'hBEEF;
    serve();
    i_req = 1'b1; i_addr = 16'h1236;
    idle_gap();
    serve();

    // Two back-to-back collisions: D re-requests as soon as it finishes.
    i_req = 1'b1; i_addr = 16'($urandom);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
    idle_gap();
    serve();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
    idle_gap();
    serve();
    idle_gap();
    serve();

    i_req = 1'b1; i_addr = 16'h2A5C;
    idle_gap();
    last_d_m = 1'b0;
    @(negedge clk);
    expect_fill(1'b0, 16'h2A5C, 2, -1);

    i_req = 1'b1; i_addr = 16'h7F10;
    idle_gap();
    last_d_m = 1'b0;
    @(negedge clk);
    expect_fill(1'b0, 16'h7F10, -1, 6);
    rst = 1'b1;
    i_req = 1'b0;
    #1;
    chk("arst_gnt", {i_gnt, d_gnt}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mem", {mem_en, mem_wr}, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_fill", {fill_valid, 16'(fill_data), 3'(fill_word)}, 0);
    chk("arst_done", {i_done, d_done}, 0);
    last_d_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      chk("post_rst_fill_valid", fill_valid, 0);
      chk("post_rst_done", {i_done, d_done}, 0);
      chk("post_rst_busy", busy, 0);
    end
    stray_pulse();

    raise_random();
    for (int it = 0; it < 16; it++) begin
      serve();
      if (!i_req && !d_req) raise_random();
      idle_gap();
    end
    while (i_req || d_req) begin
      serve();
      idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
